router_pkt_ingress: RTL and testbench

- Write-side controller for the router's three per-destination output FIFOs.
- Accepts a byte-serial packet from the source port, decodes the header, and steers header, payload and parity bytes into the selected FIFO using write_enb and lfd_state.
- Checks packet parity.
- Applies backpressure to the source through busy whenever the target FIFO cannot take a byte.

---
 rtl/router_pkt_ingress.sv | 171 +++++++++++++++++
 tb/tb_router_pkt_ingress.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_ingress.sv
// Write-side controller for the router's per-destination output FIFOs: header decode,
// byte steering, parity check and source backpressure. Optional counters: ROUTER_PKT_COUNT_EN.
module router_pkt_ingress #(
   parameter int NUM_DEST = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                pkt_valid,
   input  logic [7:0]          data_in,
   input  logic [NUM_DEST-1:0] fifo_full,
   input  logic [NUM_DEST-1:0] fifo_empty,
   input  logic [NUM_DEST-1:0] soft_reset,
   output logic                busy,
   output logic [NUM_DEST-1:0] write_enb,
   output logic                lfd_state,
   output logic [7:0]          data_out,
   output logic                parity_done,
   output logic                err
`ifdef ROUTER_PKT_COUNT_EN
   ,
   output logic [CNT_W-1:0]    pkt_count,
   output logic [7:0]          err_count
`endif
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_LOAD_DATA    = 3'd1;
   localparam logic [2:0] S_LOAD_PARITY  = 3'd2;
   localparam logic [2:0] S_CHECK_PARITY = 3'd3;
   localparam logic [2:0] S_DROP         = 3'd4;

   logic [2:0] state_q, state_d;
   logic [1:0] dest_q, dest_d;
   // One bit wider than the length field: an invalid header with L=63 owes 64 bytes.
   logic [6:0] rem_q, rem_d;
   logic [7:0] par_q, par_d;
   logic       err_q, err_d;
   logic       pdone_q, pdone_d;

   logic [1:0] hdr_addr;
   logic [5:0] hdr_len;
   logic       hdr_valid;
   logic       busy_c, acc, wr, lfd_c;
   logic [1:0] wr_dest;

   assign hdr_addr  = data_in[1:0];
   assign hdr_len   = data_in[7:2];
   assign hdr_valid = int'(hdr_addr) < NUM_DEST;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      rem_d   = rem_q;
      par_d   = par_q;
      err_d   = err_q;
      pdone_d = 1'b0;
      busy_c  = 1'b0;
      acc     = 1'b0;
      wr      = 1'b0;
      lfd_c   = 1'b0;
      wr_dest = dest_q;
      case (state_q)
         S_IDLE: begin
            if (hdr_valid) begin
               busy_c = pkt_valid & ~fifo_empty[hdr_addr];
               acc    = pkt_valid & ~busy_c;
               if (acc) begin
                  wr      = 1'b1;
                  lfd_c   = 1'b1;
                  wr_dest = hdr_addr;
                  dest_d  = hdr_addr;
                  rem_d   = {1'b0, hdr_len};
                  par_d   = data_in;
                  err_d   = 1'b0;
                  state_d = (hdr_len != 6'd0) ? S_LOAD_DATA : S_LOAD_PARITY;
               end
            end else if (pkt_valid) begin
               rem_d   = {1'b0, hdr_len} + 7'd1;
               state_d = S_DROP;
            end
         end
         S_LOAD_DATA: begin
            busy_c = fifo_full[dest_q];
            acc    = pkt_valid & ~busy_c;
            if (soft_reset[dest_q]) begin
               // A byte taken in the flush cycle is discarded and no longer owed.
               rem_d   = acc ? rem_q : rem_q + 7'd1;
               state_d = S_DROP;
            end else if (acc) begin
               wr    = 1'b1;
               par_d = par_q ^ data_in;
               rem_d = rem_q - 7'd1;
               if (rem_q == 7'd1) state_d = S_LOAD_PARITY;
            end
         end
         S_LOAD_PARITY: begin
            busy_c = fifo_full[dest_q];
            acc    = pkt_valid & ~busy_c;
            if (soft_reset[dest_q]) begin
               rem_d   = acc ? 7'd0 : 7'd1;
               state_d = acc ? S_IDLE : S_DROP;
            end else if (acc) begin
               wr      = 1'b1;
               par_d   = par_q ^ data_in;
               pdone_d = 1'b1;
               state_d = S_CHECK_PARITY;
            end
         end
         S_CHECK_PARITY: begin
            busy_c  = 1'b1;
            err_d   = |par_q;
            state_d = S_IDLE;
         end
         S_DROP: begin
            if (pkt_valid) begin
               rem_d = rem_q - 7'd1;
               if (rem_q <= 7'd1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         dest_q  <= 2'd0;
         rem_q   <= 7'd0;
         par_q   <= 8'h00;
         err_q   <= 1'b0;
         pdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         rem_q   <= rem_d;
         par_q   <= par_d;
         err_q   <= err_d;
         pdone_q <= pdone_d;
      end
   end

   assign busy        = resetn & busy_c;
   assign write_enb   = (resetn && wr) ? (NUM_DEST'(1) << wr_dest) : '0;
   assign lfd_state   = resetn & lfd_c;
   assign data_out    = (resetn && wr) ? data_in : 8'h00;
   assign parity_done = resetn & pdone_q;
   assign err         = resetn & err_q;

`ifdef ROUTER_PKT_COUNT_EN
   logic [CNT_W-1:0] pkt_cnt_q;
   logic [7:0]       err_cnt_q;

   // pdone_q marks the CHECK_PARITY cycle, where par_q holds the residual XOR.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= 8'h00;
      end else if (pdone_q) begin
         pkt_cnt_q <= pkt_cnt_q + 1'b1;
         if ((|par_q) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'h01;
      end
   end

   assign pkt_count = resetn ? pkt_cnt_q : '0;
   assign err_count = resetn ? err_cnt_q : 8'h00;
`endif

endmodule

// File: tb/tb_router_pkt_ingress.sv
// Directed self-checking bench for router_pkt_ingress (counter checks under ROUTER_PKT_COUNT_EN).
module tb_router_pkt_ingress;

   logic       clk;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       busy;
   logic [2:0] write_enb;
   logic       lfd_state;
   logic [7:0] data_out;
   logic       parity_done;
   logic       err;
`ifdef ROUTER_PKT_COUNT_EN
   logic [15:0] pkt_count;
   logic [7:0]  err_count;
`endif

   int checks = 0;
   int errors = 0;
   logic rn_next = 1'b0;

   router_pkt_ingress #(.NUM_DEST(3), .CNT_W(16)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .pkt_valid   (pkt_valid),
      .data_in     (data_in),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .soft_reset  (soft_reset),
      .busy        (busy),
      .write_enb   (write_enb),
      .lfd_state   (lfd_state),
      .data_out    (data_out),
      .parity_done (parity_done),
      .err         (err)
`ifdef ROUTER_PKT_COUNT_EN
      ,
      .pkt_count   (pkt_count),
      .err_count   (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
   task automatic cyc(input logic pv, input logic [7:0] d, input logic [2:0] emp,
                      input logic [2:0] full, input logic [2:0] srst);
      @(negedge clk);
      resetn     = rn_next;
      pkt_valid  = pv;
      data_in    = d;
      fifo_empty = emp;
      fifo_full  = full;
      soft_reset = srst;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic b, input logic [2:0] we, input logic lfd,
                             input logic [7:0] dout, input logic pd, input logic e);
      check({tag, ".busy"},        32'(busy),        32'(b));
      check({tag, ".write_enb"},   32'(write_enb),   32'(we));
      check({tag, ".lfd_state"},   32'(lfd_state),   32'(lfd));
      check({tag, ".data_out"},    32'(data_out),    32'(dout));
      check({tag, ".parity_done"}, 32'(parity_done), 32'(pd));
      check({tag, ".err"},         32'(err),         32'(e));
   endtask

   initial begin
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
      fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;

      // Reset with a live source byte: all outputs must stay inactive.
      rn_next = 1'b0;
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("rst0", 0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("rst1", 0, 3'b000, 0, 8'h00, 0, 0);
      rn_next = 1'b1;
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("idle", 0, 3'b000, 0, 8'h00, 0, 0);

      // Normal packet to FIFO 1, L=3, parity 0D.
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("n.hdr", 0, 3'b010, 1, 8'h0D, 0, 0);
      cyc(1'b1, 8'h11, 3'b111, 3'b000, 3'b000); expect_out("n.d0",  0, 3'b010, 0, 8'h11, 0, 0);
      cyc(1'b1, 8'h22, 3'b111, 3'b000, 3'b000); expect_out("n.d1",  0, 3'b010, 0, 8'h22, 0, 0);
      cyc(1'b1, 8'h33, 3'b111, 3'b000, 3'b000); expect_out("n.d2",  0, 3'b010, 0, 8'h33, 0, 0);
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("n.par", 0, 3'b010, 0, 8'h0D, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("n.chk", 1, 3'b000, 0, 8'h00, 1, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("n.end", 0, 3'b000, 0, 8'h00, 0, 0);

      // Same packet, wrong parity 0C: err rises after parity_done and holds.
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("b.hdr", 0, 3'b010, 1, 8'h0D, 0, 0);
      cyc(1'b1, 8'h11, 3'b111, 3'b000, 3'b000); expect_out("b.d0",  0, 3'b010, 0, 8'h11, 0, 0);
      cyc(1'b1, 8'h22, 3'b111, 3'b000, 3'b000); expect_out("b.d1",  0, 3'b010, 0, 8'h22, 0, 0);
      cyc(1'b1, 8'h33, 3'b111, 3'b000, 3'b000); expect_out("b.d2",  0, 3'b010, 0, 8'h33, 0, 0);
      cyc(1'b1, 8'h0C, 3'b111, 3'b000, 3'b000); expect_out("b.par", 0, 3'b010, 0, 8'h0C, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("b.chk", 1, 3'b000, 0, 8'h00, 1, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("b.err0", 0, 3'b000, 0, 8'h00, 0, 1);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("b.err1", 0, 3'b000, 0, 8'h00, 0, 1);
      // Header 00 (addr 0, L=0) clears err once accepted.
      cyc(1'b1, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("z.hdr", 0, 3'b001, 1, 8'h00, 0, 1);
      cyc(1'b1, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("z.par", 0, 3'b001, 0, 8'h00, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("z.chk", 1, 3'b000, 0, 8'h00, 1, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("z.end", 0, 3'b000, 0, 8'h00, 0, 0);

      // Header 04 waits four cycles for FIFO 0 to drain; parity 04^AA = AE.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'h04, 3'b110, 3'b000, 3'b000); expect_out("w.wait", 1, 3'b000, 0, 8'h00, 0, 0);
      end
      cyc(1'b1, 8'h04, 3'b111, 3'b000, 3'b000); expect_out("w.hdr", 0, 3'b001, 1, 8'h04, 0, 0);
      cyc(1'b1, 8'hAA, 3'b111, 3'b000, 3'b000); expect_out("w.d0",  0, 3'b001, 0, 8'hAA, 0, 0);
      cyc(1'b1, 8'hAE, 3'b111, 3'b000, 3'b000); expect_out("w.par", 0, 3'b001, 0, 8'hAE, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("w.chk", 1, 3'b000, 0, 8'h00, 1, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("w.end", 0, 3'b000, 0, 8'h00, 0, 0);

      // FIFO 2 full for three payload cycles; parity 0A^55^66 = 39.
      cyc(1'b1, 8'h0A, 3'b111, 3'b000, 3'b000); expect_out("f.hdr", 0, 3'b100, 1, 8'h0A, 0, 0);
      cyc(1'b1, 8'h55, 3'b111, 3'b000, 3'b000); expect_out("f.d0",  0, 3'b100, 0, 8'h55, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'h66, 3'b111, 3'b100, 3'b000); expect_out("f.full", 1, 3'b000, 0, 8'h00, 0, 0);
      end
      cyc(1'b1, 8'h66, 3'b111, 3'b000, 3'b000); expect_out("f.d1",  0, 3'b100, 0, 8'h66, 0, 0);
      cyc(1'b1, 8'h39, 3'b111, 3'b000, 3'b000); expect_out("f.par", 0, 3'b100, 0, 8'h39, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("f.chk", 1, 3'b000, 0, 8'h00, 1, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("f.end", 0, 3'b000, 0, 8'h00, 0, 0);
`ifdef ROUTER_PKT_COUNT_EN
      check("cnt.pkt_pre", 32'(pkt_count), 32'd5);
      check("cnt.err_pre", 32'(err_count), 32'd1);
`endif

      // Invalid address 3, L=2: header plus three bytes silently consumed.
      cyc(1'b1, 8'h0B, 3'b111, 3'b000, 3'b000); expect_out("i.hdr", 0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h01, 3'b111, 3'b000, 3'b000); expect_out("i.b0",  0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h02, 3'b111, 3'b000, 3'b000); expect_out("i.b1",  0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h03, 3'b111, 3'b000, 3'b000); expect_out("i.b2",  0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("i.end", 0, 3'b000, 0, 8'h00, 0, 0);

      // Soft reset of FIFO 1 after the first payload byte: three owed bytes are dropped.
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("s.hdr", 0, 3'b010, 1, 8'h0D, 0, 0);
      cyc(1'b1, 8'h11, 3'b111, 3'b000, 3'b000); expect_out("s.d0",  0, 3'b010, 0, 8'h11, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b010); expect_out("s.srst", 0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h22, 3'b111, 3'b000, 3'b000); expect_out("s.x0",  0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h33, 3'b111, 3'b000, 3'b000); expect_out("s.x1",  0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("s.x2",  0, 3'b000, 0, 8'h00, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("s.end", 0, 3'b000, 0, 8'h00, 0, 0);

      // Reset in LOAD_DATA, then header 05 (addr 1, L=1), parity 05^77 = 72.
      cyc(1'b1, 8'h0D, 3'b111, 3'b000, 3'b000); expect_out("r.hdr", 0, 3'b010, 1, 8'h0D, 0, 0);
      cyc(1'b1, 8'h11, 3'b111, 3'b000, 3'b000); expect_out("r.d0",  0, 3'b010, 0, 8'h11, 0, 0);
      rn_next = 1'b0;
      cyc(1'b1, 8'h22, 3'b111, 3'b000, 3'b000); expect_out("r.rst", 0, 3'b000, 0, 8'h00, 0, 0);
      rn_next = 1'b1;
      cyc(1'b1, 8'h05, 3'b111, 3'b000, 3'b000); expect_out("r.hdr2", 0, 3'b010, 1, 8'h05, 0, 0);
`ifdef ROUTER_PKT_COUNT_EN
      check("cnt.pkt_rst", 32'(pkt_count), 32'd0);
      check("cnt.err_rst", 32'(err_count), 32'd0);
`endif
      cyc(1'b1, 8'h77, 3'b111, 3'b000, 3'b000); expect_out("r.d1",  0, 3'b010, 0, 8'h77, 0, 0);
      cyc(1'b1, 8'h72, 3'b111, 3'b000, 3'b000); expect_out("r.par", 0, 3'b010, 0, 8'h72, 0, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("r.chk", 1, 3'b000, 0, 8'h00, 1, 0);
      cyc(1'b0, 8'h00, 3'b111, 3'b000, 3'b000); expect_out("r.end", 0, 3'b000, 0, 8'h00, 0, 0);
`ifdef ROUTER_PKT_COUNT_EN
      check("cnt.pkt_post", 32'(pkt_count), 32'd1);
      check("cnt.err_post", 32'(err_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
